// File: rtl/aes_pkg.sv
// Shared constants and types for the AES ciphertext serializer slice.
// Block/word geometry and the most-significant-word-first word selector.
package aes_pkg;

    localparam int AES_BLK_W         = 128;
    localparam int AES_WORD_W        = 32;
    localparam int AES_WORDS_PER_BLK = 4;

    typedef logic [1:0] word_idx_t;

    localparam word_idx_t LAST_WORD_IDX = 2'd3;

    typedef enum logic {
        RD_EMPTY  = 1'b0,
        RD_STREAM = 1'b1
    } rd_state_e;

    // Word 0 is the most significant 32 bits, which keeps FIPS-197 byte order on the wire.
    function automatic logic [AES_WORD_W-1:0] select_word(
        input logic [AES_BLK_W-1:0] blk,
        input word_idx_t            idx
    );
        logic [AES_WORD_W-1:0] w;
        case (idx)
            2'd0:    w = blk[127:96];
            2'd1:    w = blk[95:64];
            2'd2:    w = blk[63:32];
            default: w = blk[31:0];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/aes_blk_fifo.sv
// Block FIFO holding whole 128-bit ciphertext blocks; DEPTH must be a power of two.
// A push while full is still accepted when a pop happens on the same edge.
module aes_blk_fifo
    import aes_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push_i,
    input  logic                 pop_i,
    input  logic [AES_BLK_W-1:0] data_i,
    output logic [AES_BLK_W-1:0] head_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [AW:0]          count_o
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AES_BLK_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [AW:0]          count_q,  count_d;
    logic                 pop_ok;
    logic                 accept;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign pop_ok = pop_i && !empty_o;
    assign accept = push_i && (!full_o || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({accept, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left unreset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/aes_ct_serializer.sv
// Buffers ciphertext blocks from the non-stallable AES core and replays each as four 32-bit words.
// Define AES_SER_OVF_CNT_EN to build the saturating dropped-block counter behind ovf_count.
module aes_ct_serializer
    import aes_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [AES_BLK_W-1:0]  in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [AES_WORD_W-1:0] out_data,
    output logic                  out_last,
    output logic                  overflow,
    input  logic                  clr_ovf,
    output logic [7:0]            ovf_count,
    output logic [AW:0]           level
);

    logic [AES_BLK_W-1:0] head_blk;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;
    logic                 drop;
    rd_state_e            rd_state;
    word_idx_t            word_idx_q, word_idx_d;
    logic                 overflow_q, overflow_d;

    aes_blk_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (in_valid),
        .pop_i   (pop),
        .data_i  (in_data),
        .head_o  (head_blk),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (level)
    );

    assign rd_state = fifo_empty ? RD_EMPTY : RD_STREAM;

    always_comb begin
        out_valid  = 1'b0;
        out_data   = '0;
        out_last   = 1'b0;
        pop        = 1'b0;
        word_idx_d = word_idx_q;
        case (rd_state)
            RD_STREAM: begin
                out_valid = 1'b1;
                out_data  = select_word(head_blk, word_idx_q);
                out_last  = (word_idx_q == LAST_WORD_IDX);
                if (out_ready) begin
                    if (word_idx_q == LAST_WORD_IDX) begin
                        word_idx_d = '0;
                        pop        = 1'b1;
                    end else begin
                        word_idx_d = word_idx_q + 2'd1;
                    end
                end
            end
            default: begin
                word_idx_d = word_idx_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_idx_q <= '0;
        end else begin
            word_idx_q <= word_idx_d;
        end
    end

    // A retire on the same edge frees a slot, so only a truly full FIFO drops.
    assign drop = in_valid && fifo_full && !pop;

    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;

`ifdef AES_SER_OVF_CNT_EN
    logic [7:0] ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (clr_ovf) begin
            ovf_cnt_d = drop ? 8'd1 : 8'd0;
        end else if (drop && (ovf_cnt_q != 8'hFF)) begin
            ovf_cnt_d = ovf_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_cnt_q <= 8'd0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign ovf_count = ovf_cnt_q;
`else
    assign ovf_count = 8'h00;
`endif

endmodule

// File: tb/tb_aes_ct_serializer.sv
// Directed self-checking bench for aes_ct_serializer; inputs change on the falling edge like the core.
// Honours AES_SER_OVF_CNT_EN when forming expected ovf_count values.
module tb_aes_ct_serializer;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

`ifdef AES_SER_OVF_CNT_EN
    localparam logic [7:0] ONE_IF_CNT = 8'd1;
`else
    localparam logic [7:0] ONE_IF_CNT = 8'd0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [127:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic          out_last;
    logic          overflow;
    logic          clr_ovf;
    logic [7:0]    ovf_count;
    logic [AW:0]   level;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    aes_ct_serializer #(
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf),
        .ovf_count (ovf_count),
        .level     (level)
    );

    // Block id/word index are encoded into every word so order errors are visible.
    function automatic logic [31:0] mk_word(input logic [7:0] id, input int w);
        return {8'hA0 + 8'(w), id, 8'(w), 8'(w)};
    endfunction

    function automatic logic [127:0] mk_blk(input logic [7:0] id);
        return {mk_word(id, 0), mk_word(id, 1), mk_word(id, 2), mk_word(id, 3)};
    endfunction

    task automatic push_blocks(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = mk_blk(first + 8'(i));
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (level !== 3'd0) begin failures++; $display("[TB] FAIL reset_level: got %0d expected 0", level); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
        checks++; if (ovf_count !== 8'd0) begin failures++; $display("[TB] FAIL reset_ovf_count: got %0d expected 0", ovf_count); end
        checks++; if (out_data !== 32'd0) begin failures++; $display("[TB] FAIL reset_out_data: got %h expected 0", out_data); end
        checks++; if (out_last !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_last: got %b expected 0", out_last); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_block();
        logic [31:0] exp_w [4];
        exp_w = '{32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a};
        in_valid  = 1'b1;
        in_data   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (level !== 3'd1) begin failures++; $display("[TB] FAIL single_level: got %0d expected 1", level); end
        for (int w = 0; w < 4; w++) begin
            checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL single_valid%0d: got %b expected 1", w, out_valid); end
            checks++; if (out_data !== exp_w[w]) begin failures++; $display("[TB] FAIL single_word%0d: got %h expected %h", w, out_data, exp_w[w]); end
            checks++; if (out_last !== 1'(w == 3)) begin failures++; $display("[TB] FAIL single_last%0d: got %b expected %b", w, out_last, (w == 3)); end
            @(negedge clk);
        end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL single_end_valid: got %b expected 0", out_valid); end
        checks++; if (level !== 3'd0) begin failures++; $display("[TB] FAIL single_end_level: got %0d expected 0", level); end
        out_ready = 1'b0;
    endtask

    task automatic test_back_pressure();
        logic [31:0] exp_w [4];
        int          idx;
        exp_w = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
        idx   = 0;
        in_valid  = 1'b1;
        in_data   = 128'h00112233445566778899aabbccddeeff;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 16 && idx < 4; i++) begin
            checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL bp_valid%0d: got %b expected 1", i, out_valid); end
            checks++; if (out_data !== exp_w[idx]) begin failures++; $display("[TB] FAIL bp_word%0d: got %h expected %h", i, out_data, exp_w[idx]); end
            checks++; if (out_last !== 1'(idx == 3)) begin failures++; $display("[TB] FAIL bp_last%0d: got %b expected %b", i, out_last, (idx == 3)); end
            out_ready = ((i % 3) == 0);
            @(negedge clk);
            if (out_ready) idx++;
        end
        out_ready = 1'b0;
        checks++; if (idx != 4) begin failures++; $display("[TB] FAIL bp_timeout: got %0d words expected 4", idx); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_end_valid: got %b expected 0", out_valid); end
        checks++; if (level !== 3'd0) begin failures++; $display("[TB] FAIL bp_end_level: got %0d expected 0", level); end
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        push_blocks(8'h10, 5);
        checks++; if (level !== 3'd4) begin failures++; $display("[TB] FAIL ovf_level: got %0d expected 4", level); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_flag: got %b expected 1", overflow); end
        checks++; if (ovf_count !== ONE_IF_CNT) begin failures++; $display("[TB] FAIL ovf_count: got %0d expected %0d", ovf_count, ONE_IF_CNT); end
        out_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            for (int w = 0; w < 4; w++) begin
                checks++; if (out_data !== mk_word(8'h10 + 8'(b), w)) begin failures++; $display("[TB] FAIL ovf_drain_b%0d_w%0d: got %h expected %h", b, w, out_data, mk_word(8'h10 + 8'(b), w)); end
                checks++; if (out_last !== 1'(w == 3)) begin failures++; $display("[TB] FAIL ovf_drain_last_b%0d_w%0d: got %b expected %b", b, w, out_last, (w == 3)); end
                @(negedge clk);
            end
        end
        out_ready = 1'b0;
        checks++; if (level !== 3'd0) begin failures++; $display("[TB] FAIL ovf_drain_level: got %0d expected 0", level); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL ovf_drain_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_clr_ovf();
        out_ready = 1'b0;
        push_blocks(8'h20, 4);
        in_valid = 1'b1;
        in_data  = mk_blk(8'h2F);
        clr_ovf  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        clr_ovf  = 1'b0;
        checks++; if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL clr_drop_flag: got %b expected 1", overflow); end
        checks++; if (ovf_count !== ONE_IF_CNT) begin failures++; $display("[TB] FAIL clr_drop_count: got %0d expected %0d", ovf_count, ONE_IF_CNT); end
        checks++; if (level !== 3'd4) begin failures++; $display("[TB] FAIL clr_drop_level: got %0d expected 4", level); end
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL clr_only_flag: got %b expected 0", overflow); end
        checks++; if (ovf_count !== 8'd0) begin failures++; $display("[TB] FAIL clr_only_count: got %0d expected 0", ovf_count); end
        out_ready = 1'b1;
        repeat (16) @(negedge clk);
        out_ready = 1'b0;
        checks++; if (level !== 3'd0) begin failures++; $display("[TB] FAIL clr_drain_level: got %0d expected 0", level); end
    endtask

    task automatic test_full_retire();
        out_ready = 1'b0;
        push_blocks(8'h30, 4);
        checks++; if (level !== 3'd4) begin failures++; $display("[TB] FAIL fr_fill_level: got %0d expected 4", level); end
        out_ready = 1'b1;
        for (int w = 0; w < 3; w++) begin
            checks++; if (out_data !== mk_word(8'h30, w)) begin failures++; $display("[TB] FAIL fr_head_w%0d: got %h expected %h", w, out_data, mk_word(8'h30, w)); end
            @(negedge clk);
        end
        checks++; if (out_last !== 1'b1) begin failures++; $display("[TB] FAIL fr_head_last: got %b expected 1", out_last); end
        checks++; if (out_data !== mk_word(8'h30, 3)) begin failures++; $display("[TB] FAIL fr_head_w3: got %h expected %h", out_data, mk_word(8'h30, 3)); end
        in_valid = 1'b1;
        in_data  = mk_blk(8'h34);
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (level !== 3'd4) begin failures++; $display("[TB] FAIL fr_level: got %0d expected 4", level); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL fr_overflow: got %b expected 0", overflow); end
        for (int b = 1; b < 5; b++) begin
            for (int w = 0; w < 4; w++) begin
                checks++; if (out_data !== mk_word(8'h30 + 8'(b), w)) begin failures++; $display("[TB] FAIL fr_drain_b%0d_w%0d: got %h expected %h", b, w, out_data, mk_word(8'h30 + 8'(b), w)); end
                @(negedge clk);
            end
        end
        out_ready = 1'b0;
        checks++; if (level !== 3'd0) begin failures++; $display("[TB] FAIL fr_end_level: got %0d expected 0", level); end
    endtask

    task automatic test_reset_mid_block();
        out_ready = 1'b0;
        push_blocks(8'h40, 5);
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (out_data !== mk_word(8'h40, 2)) begin failures++; $display("[TB] FAIL rm_pre_word: got %h expected %h", out_data, mk_word(8'h40, 2)); end
        #2 reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rm_valid: got %b expected 0", out_valid); end
        checks++; if (level !== 3'd0) begin failures++; $display("[TB] FAIL rm_level: got %0d expected 0", level); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL rm_overflow: got %b expected 0", overflow); end
        checks++; if (ovf_count !== 8'd0) begin failures++; $display("[TB] FAIL rm_ovf_count: got %0d expected 0", ovf_count); end
        checks++; if (out_data !== 32'd0) begin failures++; $display("[TB] FAIL rm_out_data: got %h expected 0", out_data); end
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = mk_blk(8'h50);
        @(negedge clk);
        in_valid = 1'b0;
        for (int w = 0; w < 4; w++) begin
            checks++; if (out_data !== mk_word(8'h50, w)) begin failures++; $display("[TB] FAIL rm_new_w%0d: got %h expected %h", w, out_data, mk_word(8'h50, w)); end
            checks++; if (out_last !== 1'(w == 3)) begin failures++; $display("[TB] FAIL rm_new_last%0d: got %b expected %b", w, out_last, (w == 3)); end
            @(negedge clk);
        end
        out_ready = 1'b0;
        checks++; if (level !== 3'd0) begin failures++; $display("[TB] FAIL rm_end_level: got %0d expected 0", level); end
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        test_reset();
        test_single_block();
        test_back_pressure();
        test_overflow();
        test_clr_ovf();
        test_full_retire();
        test_reset_mid_block();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_ct_serializer.md
Name: aes_ct_serializer

Overview:
Downstream neighbour of the 10-stage AES-128 pipeline core. It captures each 128-bit ciphertext block the core emits, tagged by a valid bit the integrator delays to match core latency. Blocks are buffered in a small FIFO because the core cannot stall. Each block is replayed as four 32-bit words over a valid/ready stream to the bus or host interface.

Parameters:
DEPTH, 4, number of 128-bit blocks buffered; power of two, 2..16.
AW, $clog2(DEPTH), pointer width; derived, do not override.

Ports:
clk  input  1  single clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
in_valid  input  1  ciphertext-valid tag aligned with in_data.
in_data  input  128  ciphertext block from the core output register (bits 127:0, FIPS-197 byte order).
out_valid  output  1  current word available.
out_ready  input  1  consumer accepts word when high together with out_valid.
out_data  output  32  current word.
out_last  output  1  high on the 4th (final) word of a block.
overflow  output  1  sticky: a block was dropped.
clr_ovf  input  1  synchronous clear of overflow (and drop counter if compiled).
ovf_count  output  8  dropped-block count (see Optional Feature).
level  output  AW+1  blocks currently stored (0..DEPTH).

Behaviour:
- Reset (reset=0, async): wr_ptr, rd_ptr, count, word_idx, overflow, ovf_count all 0; out_valid=0, out_last=0, out_data=0, level=0. Stored block contents need not be cleared.
- Core output changes on the falling clock edge. in_data/in_valid are therefore stable half a cycle before the rising edge and are sampled directly, with no resynchronising.
- The read side has two implicit states:
  - EMPTY: count==0, out_valid=0.
  - STREAM: count>0, out_valid=1.
- out_data = head block word selected by word_idx: 0→[127:96], 1→[95:64], 2→[63:32], 3→[31:0]. Most-significant word first.
- out_data and out_last are combinational from registers only; no input-to-output comb path. out_data=0 when EMPTY.
- Word handshake (out_valid & out_ready at a rising edge):
  - word_idx<3: word_idx increments.
  - word_idx==3: word_idx wraps to 0, rd_ptr increments (mod DEPTH) and the block retires.
  - out_data must be held stable while out_valid & !out_ready.
- Write: in_valid at a rising edge writes in_data at wr_ptr and increments wr_ptr, when either condition holds:
  - count<DEPTH, or
  - a retire occurs in the same cycle. Full plus simultaneous retire is accepted, count stays DEPTH.
- Drop: in_valid, count==DEPTH and no retire. Data is discarded, pointers are unchanged, overflow is set to 1.
- count update per cycle: +1 on write only, -1 on retire only, unchanged on both or neither. level=count.
- Latency: a block written at edge N gives out_valid=1 after edge N. The first word is consumable at edge N+1. Minimum 4 cycles per block on the output.
- clr_ovf=1 clears overflow at the edge. If a drop happens in the same cycle, set wins (overflow=1).
- Reset asserted mid-block: partially sent block is discarded; after release, output resumes from EMPTY with word_idx=0.

Optional Feature:
AES_SER_OVF_CNT_EN
- Defined: ovf_count is an 8-bit counter, +1 per dropped block, saturating at 255. clr_ovf zeroes it; a drop in the same cycle as clr_ovf gives ovf_count=1.
- Undefined: no counter logic; ovf_count tied to 8'h00. The overflow flag is unaffected either way.

Decomposition:
- Shared package aes_pkg: AES_BLK_W=128, AES_WORD_W=32, AES_WORDS_PER_BLK=4, and a word-index typedef (2 bits).
- One sub-module, aes_blk_fifo: storage array, pointers and count, with push/pop/full/empty and accept-on-pop-when-full.
- Word mux, word_idx counter, overflow logic and optional counter stay in the top.

Test Plan:
1. Single block, key 000102..0f, plaintext 00112233..ff, in_data=69c4e0d86a7b0430d8cdb78070b4c55a, out_ready=1 → words 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a on 4 consecutive cycles; out_last only on 4th; then out_valid=0.
2. Back-pressure: out_ready toggles 1,0,0,1,... → out_data held during stalls, no word skipped or repeated, level returns to 0.
3. DEPTH=4, out_ready=0, 5 blocks presented → level=4, 5th dropped, overflow=1, ovf_count=1 with macro (0 without). Draining yields blocks 1-4 intact.
4. FIFO full, 5th block arrives on the edge where the head's 4th word is accepted → accepted, overflow stays 0, level stays 4, order preserved.
5. reset pulsed low after 2 words of a block → out_valid, level, overflow drop to 0 asynchronously; post-release, new block streams from word 0.
6. clr_ovf and a drop on the same edge → overflow=1; clr_ovf alone afterwards → 0 (ovf_count 0 with macro).
